// File: rtl/comparator_8bit.sv
// comparator_8bit
// Registered magnitude comparator with unsigned / two's-complement ordering.
// One combinational stage (p0) decides ordering from a single (WIDTH+1)-bit
// subtraction, then one register stage (p1) drives all outputs. Latency is
// exactly one clock. Results hold whenever in_valid is low.
module comparator_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic             a_gt_b,
  output logic             a_eq_b,
  output logic             a_lt_b,
  output logic [WIDTH-1:0] max_out,
  output logic [WIDTH-1:0] min_out,
  output logic [WIDTH-1:0] abs_diff
);

  // Ordering decision from the zero-extended difference a - b.
  // Unsigned: bit WIDTH is the borrow, set exactly when a < b.
  // Signed: the low WIDTH bits form the two's-complement difference; its
  // sign bit is wrong only on overflow, so sign XOR overflow gives a < b.
  function automatic logic f_a_less(
    input logic [WIDTH:0] diff,
    input logic           a_msb,
    input logic           b_msb,
    input logic           sm
  );
    logic ovf;
    ovf = (a_msb != b_msb) && (diff[WIDTH-1] != a_msb);
    if (sm) begin
      return diff[WIDTH-1] ^ ovf;
    end
    return diff[WIDTH];
  endfunction

  // Magnitude of the separation between the two ordered operands. Taken
  // modulo 2^WIDTH; in signed mode the true distance never exceeds
  // 2^WIDTH-1, so it always reads correctly as an unsigned value.
  function automatic logic [WIDTH-1:0] f_mag(
    input logic [WIDTH-1:0] hi,
    input logic [WIDTH-1:0] lo
  );
    return hi - lo;
  endfunction

  // ---- stage p0: combinational compare on the sampled inputs ----
  logic [WIDTH:0]   w_diff_p0;
  logic             w_lt_p0;
  logic             w_eq_p0;
  logic             w_gt_p0;
  logic [WIDTH-1:0] w_max_p0;
  logic [WIDTH-1:0] w_min_p0;
  logic [WIDTH-1:0] w_abs_p0;

  assign w_diff_p0 = {1'b0, a} - {1'b0, b};
  assign w_eq_p0   = (a == b);
  assign w_lt_p0   = f_a_less(w_diff_p0, a[WIDTH-1], b[WIDTH-1], signed_mode);
  assign w_gt_p0   = ~w_lt_p0 & ~w_eq_p0;
  // On equality a is reported as max and b as min.
  assign w_max_p0  = w_lt_p0 ? b : a;
  assign w_min_p0  = w_lt_p0 ? a : b;
  assign w_abs_p0  = f_mag(w_max_p0, w_min_p0);

  // ---- stage p1: output registers ----
  logic             r_vld_p1;
  logic             r_gt_p1;
  logic             r_eq_p1;
  logic             r_lt_p1;
  logic [WIDTH-1:0] r_max_p1;
  logic [WIDTH-1:0] r_min_p1;
  logic [WIDTH-1:0] r_abs_p1;

  // Valid flag: registered copy of in_valid, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1 <= 1'b0;
    end else begin
      r_vld_p1 <= in_valid;
    end
  end

  // Result registers: reset to the "0 vs 0" comparison, load on in_valid, else hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gt_p1  <= 1'b0;
      r_eq_p1  <= 1'b1;
      r_lt_p1  <= 1'b0;
      r_max_p1 <= '0;
      r_min_p1 <= '0;
      r_abs_p1 <= '0;
    end else if (in_valid) begin
      r_gt_p1  <= w_gt_p0;
      r_eq_p1  <= w_eq_p0;
      r_lt_p1  <= w_lt_p0;
      r_max_p1 <= w_max_p0;
      r_min_p1 <= w_min_p0;
      r_abs_p1 <= w_abs_p0;
    end
  end

  assign out_valid = r_vld_p1;
  assign a_gt_b    = r_gt_p1;
  assign a_eq_b    = r_eq_p1;
  assign a_lt_b    = r_lt_p1;
  assign max_out   = r_max_p1;
  assign min_out   = r_min_p1;
  assign abs_diff  = r_abs_p1;

endmodule

// File: tb/tb_comparator_8bit.sv
// tb_comparator_8bit
// Directed and randomized checks of comparator_8bit against an integer
// reference model of the ordering rules.
module tb_comparator_8bit;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       signed_mode;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       a_gt_b;
  logic       a_eq_b;
  logic       a_lt_b;
  logic [7:0] max_out;
  logic [7:0] min_out;
  logic [7:0] abs_diff;

  int n_cmp;
  int n_err;

  // expected output state
  logic       e_vld;
  logic       e_gt;
  logic       e_eq;
  logic       e_lt;
  logic [7:0] e_max;
  logic [7:0] e_min;
  logic [7:0] e_abs;

  comparator_8bit #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .a_gt_b      (a_gt_b),
    .a_eq_b      (a_eq_b),
    .a_lt_b      (a_lt_b),
    .max_out     (max_out),
    .min_out     (min_out),
    .abs_diff    (abs_diff)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".vld"}, 32'(out_valid), 32'(e_vld));
    chk({tag, ".gt"},  32'(a_gt_b),    32'(e_gt));
    chk({tag, ".eq"},  32'(a_eq_b),    32'(e_eq));
    chk({tag, ".lt"},  32'(a_lt_b),    32'(e_lt));
    chk({tag, ".max"}, 32'(max_out),   32'(e_max));
    chk({tag, ".min"}, 32'(min_out),   32'(e_min));
    chk({tag, ".abs"}, 32'(abs_diff),  32'(e_abs));
  endtask

  task automatic model_reset();
    e_vld = 1'b0; e_gt = 1'b0; e_eq = 1'b1; e_lt = 1'b0;
    e_max = 8'd0; e_min = 8'd0; e_abs = 8'd0;
  endtask

  // Reference: interpret operands as integers in the selected ordering.
  task automatic model_load(input logic [7:0] ta, input logic [7:0] tb_, input logic sm);
    int av;
    int bv;
    int d;
    av = sm ? int'($signed(ta)) : int'(ta);
    bv = sm ? int'($signed(tb_)) : int'(tb_);
    d  = (av > bv) ? av - bv : bv - av;
    e_gt  = (av > bv);
    e_eq  = (av == bv);
    e_lt  = (av < bv);
    e_max = (av >= bv) ? ta : tb_;
    e_min = (av >= bv) ? tb_ : ta;
    e_abs = d[7:0];
  endtask

  // Called at a falling edge: drive one cycle of input, then check after the next rising edge.
  task automatic step(input logic v, input logic [7:0] ta, input logic [7:0] tb_,
                      input logic sm, input string tag);
    in_valid    = v;
    a           = ta;
    b           = tb_;
    signed_mode = sm;
    e_vld = v;
    if (v) model_load(ta, tb_, sm);
    @(posedge clk);
    @(negedge clk);
    chk_all(tag);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    signed_mode = 1'b0;
    a = 8'd0;
    b = 8'd0;
    model_reset();

    repeat (2) @(negedge clk);
    chk_all("reset");
    rst = 1'b0;

    // directed examples
    step(1'b1, 8'd50,  8'd20,  1'b0, "u50_20");
    step(1'b1, 8'd100, 8'd100, 1'b0, "u100_100");
    step(1'b1, 8'd15,  8'd200, 1'b0, "u15_200");
    step(1'b1, 8'd255, 8'd1,   1'b0, "u255_1");
    step(1'b1, 8'd255, 8'd1,   1'b1, "s255_1");
    step(1'b1, 8'd127, 8'd128, 1'b1, "s127_128");
    // mode change with no accepted input must not alter held results
    step(1'b0, 8'd127, 8'd128, 1'b0, "hold_mode");

    // boundary pairs in both modes
    for (int m = 0; m < 2; m++) begin
      step(1'b1, 8'd0,   8'd0,   m[0], "bnd0_0");
      step(1'b1, 8'd255, 8'd255, m[0], "bnd255_255");
      step(1'b1, 8'd0,   8'd255, m[0], "bnd0_255");
      step(1'b1, 8'd127, 8'd128, m[0], "bnd127_128");
      step(1'b1, 8'd128, 8'd127, m[0], "bnd128_127");
    end

    // randomized stream with bubbles
    for (int i = 0; i < 400; i++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      logic       rv;
      logic       rs;
      ra = 8'($urandom_range(0, 255));
      rb = ($urandom_range(0, 7) == 0) ? ra : 8'($urandom_range(0, 255));
      rv = ($urandom_range(0, 3) != 0);
      rs = 1'($urandom_range(0, 1));
      step(rv, ra, rb, rs, "rand");
    end

    // asynchronous reset mid-cycle with a pending input
    step(1'b1, 8'd200, 8'd3, 1'b0, "pre_rst");
    in_valid = 1'b1;
    a = 8'd0;
    b = 8'd0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk_all("async_rst");
    @(posedge clk);
    @(negedge clk);
    chk_all("rst_held");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'd0, 8'd0, 1'b0, "post_rst_idle");
    end
    step(1'b1, 8'd9, 8'd250, 1'b1, "post_rst_first");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
